// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash responder.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StData,
    StIgnore
  } state_e;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  localparam int unsigned DUMMY_CYCLES = 8;
  localparam int unsigned ADDR_BITS    = 24;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes SPI pins into the system clock domain and detects SCK edges.
// SS is reset to the asserted level so a select already held low across reset
// is never mistaken for a fresh falling edge.
module spi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic spi_sck,
  input  logic spi_ss,
  input  logic spi_mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_active,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;

  // Synchronizer chains plus a delayed SCK copy for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      sck_sync  <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_d     <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign sck_rise  = sck_sync[SYNC_STAGES-1] & ~sck_d;
  assign sck_fall  = ~sck_sync[SYNC_STAGES-1] & sck_d;
  assign ss_active = ~ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI flash read responder (mode 0). Decodes 0x03 reads, fetches 32-bit words
// from a memory port and shifts bytes out MSB-first.
// Optional: define SPI_FLASH_FAST_READ_EN to accept 0x0B with 8 dummy clocks.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_ss,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              underrun
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam bit FastEn = 1'b1;
`else
  localparam bit FastEn = 1'b0;
`endif

  logic sck_rise, sck_fall, ss_active, mosi_s;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock    (clock),
    .reset    (reset),
    .spi_sck  (spi_sck),
    .spi_ss   (spi_ss),
    .spi_mosi (spi_mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_active(ss_active),
    .mosi_s   (mosi_s)
  );

  state_e                 state_q, state_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [ADDR_BITS-1:0]   shift_q, shift_d;
  logic                   fast_q, fast_d;
  logic [1:0]             lane_q, lane_d;
  logic [31:0]            hold_q, hold_d;
  logic                   hold_valid_q, hold_valid_d;
  logic [31:0]            cur_q, cur_d;
  logic                   cur_valid_q, cur_valid_d;
  logic [7:0]             out_sh_q, out_sh_d;
  logic [2:0]             out_cnt_q, out_cnt_d;
  logic                   miso_q, miso_d;
  logic                   mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]      next_addr_q, next_addr_d;
  logic                   discard_q, discard_d;
  logic                   underrun_q, underrun_d;
  logic                   ss_prev_q;

  logic                   ss_start;
  logic [ADDR_BITS-1:0]   shift_next;
  logic [ADDR_W-1:0]      byte_addr;
  logic [ADDR_W-1:0]      fetch_addr;
  logic [31:0]            src_word;
  logic [7:0]             src_byte;

  assign ss_start   = ss_active & ~ss_prev_q;
  assign shift_next = {shift_q[ADDR_BITS-2:0], mosi_s};
  assign byte_addr  = shift_next[ADDR_W-1:0];
  assign fetch_addr = {byte_addr[ADDR_W-1:2], 2'b00};
  // Bytes come from the current word, or straight from the holding buffer
  // if it has not been promoted yet.
  assign src_word   = cur_valid_q ? cur_q : hold_q;
  assign src_byte   = src_word[{lane_q, 3'b000} +: 8];

  // Next-state: command/address decode, word buffering, byte shifting.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    fast_d       = fast_q;
    lane_d       = lane_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    cur_d        = cur_q;
    cur_valid_d  = cur_valid_q;
    out_sh_d     = out_sh_q;
    out_cnt_d    = out_cnt_q;
    miso_d       = miso_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    next_addr_d  = next_addr_q;
    discard_d    = discard_q;
    underrun_d   = underrun_q;

    // Memory return; data for an aborted transfer is dropped.
    if (mem_req_q && mem_ready) begin
      mem_req_d = 1'b0;
      if (discard_q) begin
        discard_d = 1'b0;
      end else if (state_q == StData || state_q == StDummy) begin
        hold_d       = mem_rdata;
        hold_valid_d = 1'b1;
      end
    end

    // Promote the holding word once the current word is used up.
    if (hold_valid_q && !cur_valid_q) begin
      cur_d        = hold_q;
      cur_valid_d  = 1'b1;
      hold_valid_d = 1'b0;
    end

    // Prefetch whenever the holding buffer is free and nothing is in flight.
    if ((state_q == StData || state_q == StDummy) && ss_active &&
        !mem_req_q && !hold_valid_q) begin
      mem_req_d   = 1'b1;
      mem_addr_d  = next_addr_q;
      next_addr_d = next_addr_q + ADDR_W'(4);
    end

    unique case (state_q)
      StIdle: begin
        if (ss_start) begin
          state_d    = StCmd;
          bit_cnt_d  = '0;
          underrun_d = 1'b0;
        end
      end
      StCmd: begin
        if (sck_rise) begin
          shift_d   = shift_next;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            if (shift_next[7:0] == CMD_READ) begin
              state_d = StAddr;
              fast_d  = 1'b0;
            end else if (FastEn && shift_next[7:0] == CMD_FAST_READ) begin
              state_d = StAddr;
              fast_d  = 1'b1;
            end else begin
              state_d = StIgnore;
            end
          end
        end
      end
      StAddr: begin
        if (sck_rise) begin
          shift_d   = shift_next;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'(ADDR_BITS - 1)) begin
            bit_cnt_d = '0;
            lane_d    = byte_addr[1:0];
            out_cnt_d = '0;
            state_d   = fast_q ? StDummy : StData;
            // An older aborted request still in flight delays the first fetch.
            if (!mem_req_q) begin
              mem_req_d   = 1'b1;
              mem_addr_d  = fetch_addr;
              next_addr_d = fetch_addr + ADDR_W'(4);
            end else begin
              next_addr_d = fetch_addr;
            end
          end
        end
      end
      StDummy: begin
        if (sck_rise) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'(DUMMY_CYCLES - 1)) begin
            bit_cnt_d = '0;
            state_d   = StData;
          end
        end
      end
      StData: begin
        if (sck_fall) begin
          if (out_cnt_q == 3'd0) begin
            out_cnt_d = 3'd7;
            if (cur_valid_q || hold_valid_q) begin
              miso_d   = src_byte[7];
              out_sh_d = {src_byte[6:0], 1'b0};
              lane_d   = lane_q + 2'd1;
              if (cur_valid_q) begin
                if (lane_q == 2'd3) cur_valid_d = 1'b0;
              end else begin
                cur_valid_d = (lane_q != 2'd3);
              end
            end else begin
              miso_d     = 1'b0;
              out_sh_d   = '0;
              underrun_d = 1'b1;
            end
          end else begin
            miso_d    = out_sh_q[7];
            out_sh_d  = {out_sh_q[6:0], 1'b0};
            out_cnt_d = out_cnt_q - 3'd1;
          end
        end
      end
      StIgnore: begin
      end
      default: state_d = StIdle;
    endcase

    // Deselect aborts everything; a request still in flight is discarded.
    if (state_q != StIdle && !ss_active) begin
      state_d      = StIdle;
      bit_cnt_d    = '0;
      hold_valid_d = 1'b0;
      cur_valid_d  = 1'b0;
      out_cnt_d    = '0;
      out_sh_d     = '0;
      miso_d       = 1'b0;
      discard_d    = mem_req_d;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      fast_q       <= 1'b0;
      lane_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      cur_q        <= '0;
      cur_valid_q  <= 1'b0;
      out_sh_q     <= '0;
      out_cnt_q    <= '0;
      miso_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      next_addr_q  <= '0;
      discard_q    <= 1'b0;
      underrun_q   <= 1'b0;
      ss_prev_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      fast_q       <= fast_d;
      lane_q       <= lane_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      cur_q        <= cur_d;
      cur_valid_q  <= cur_valid_d;
      out_sh_q     <= out_sh_d;
      out_cnt_q    <= out_cnt_d;
      miso_q       <= miso_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      next_addr_q  <= next_addr_d;
      discard_q    <= discard_d;
      underrun_q   <= underrun_d;
      ss_prev_q    <= ss_active;
    end
  end

  assign spi_miso = miso_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign busy     = ss_active && (state_q != StIdle);
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: acts as SPI master and memory.
module tb_spi_flash_responder;

  localparam int HALF = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        spi_sck, spi_ss, spi_mosi;
  logic        spi_miso;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy, underrun;

  int          total = 0;
  int          bad = 0;
  int          mem_lat = 2;
  int          wait_cnt = 0;
  int          req_total = 0;
  logic [23:0] req_log [64];
  logic [7:0]  rx_buf [8];

  spi_flash_responder dut (
    .clock    (clock),
    .reset    (reset),
    .spi_sck  (spi_sck),
    .spi_ss   (spi_ss),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    case (a)
      24'h000000: return 32'h03020100;
      24'h000004: return 32'h44332211;
      24'h000008: return 32'h88776655;
      24'h000010: return 32'h13121110;
      24'hFFFFFC: return 32'hDDCCBBAA;
      default:    return 32'hA5A5A5A5;
    endcase
  endfunction

  // Memory responder with programmable latency; logs each served address.
  always @(posedge clock) begin
    mem_ready <= 1'b0;
    if (reset) begin
      wait_cnt <= 0;
    end else if (mem_req && !mem_ready) begin
      if (wait_cnt >= mem_lat) begin
        mem_ready              <= 1'b1;
        mem_rdata              <= mem_word(mem_addr);
        req_log[req_total % 64] <= mem_addr;
        req_total              <= req_total + 1;
        wait_cnt               <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      repeat (HALF) @(negedge clock);
      spi_sck = 1'b1;
      rx[i]   = spi_miso;
      repeat (HALF) @(negedge clock);
      spi_sck = 1'b0;
    end
  endtask

  task automatic xfer_head(input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] d;
    spi_ss = 1'b0;
    repeat (HALF) @(negedge clock);
    spi_byte(cmd, d);
    spi_byte(addr[23:16], d);
    spi_byte(addr[15:8], d);
    spi_byte(addr[7:0], d);
  endtask

  task automatic xfer_data(input int n);
    logic [7:0] r;
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, r);
      rx_buf[i] = r;
    end
  endtask

  task automatic xfer_end();
    repeat (HALF) @(negedge clock);
    spi_ss = 1'b1;
    repeat (4 * HALF) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; spi_ss = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    repeat (5) @(negedge clock);
    total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL reset_miso got %b want 0", spi_miso); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got %b want 0", mem_req); end
    total++; if (mem_addr !== 24'h0) begin bad++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got %b want 0", underrun); end
    reset = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_single_word();
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int base = req_total;
    int n4 = 0;
    xfer_head(8'h03, 24'h000004);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got %b want 1", busy); end
    xfer_data(4);
    xfer_end();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx_buf[i] !== exp[i]) begin bad++; $display("FAIL single_byte%0d got %h want %h", i, rx_buf[i], exp[i]); end
    end
    total++; if (req_log[base % 64] !== 24'h000004) begin bad++; $display("FAIL single_addr got %h want 000004", req_log[base % 64]); end
    for (int k = base; k < req_total; k++) if (req_log[k % 64] == 24'h000004) n4++;
    total++; if (n4 != 1) begin bad++; $display("FAIL single_reqcount got %0d want 1", n4); end
  endtask

  task automatic test_cross_word();
    logic [7:0] exp [6] = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    int base = req_total;
    xfer_head(8'h03, 24'h000006);
    xfer_data(6);
    xfer_end();
    for (int i = 0; i < 6; i++) begin
      total++;
      if (rx_buf[i] !== exp[i]) begin bad++; $display("FAIL cross_byte%0d got %h want %h", i, rx_buf[i], exp[i]); end
    end
    total++; if (req_log[base % 64] !== 24'h000004) begin bad++; $display("FAIL cross_req0 got %h want 000004", req_log[base % 64]); end
    total++; if (req_log[(base + 1) % 64] !== 24'h000008) begin bad++; $display("FAIL cross_req1 got %h want 000008", req_log[(base + 1) % 64]); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h01, 8'h02, 8'h03};
    int base = req_total;
    xfer_head(8'h03, 24'hFFFFFC);
    xfer_data(8);
    xfer_end();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (rx_buf[i] !== exp[i]) begin bad++; $display("FAIL wrap_byte%0d got %h want %h", i, rx_buf[i], exp[i]); end
    end
    total++; if (req_log[base % 64] !== 24'hFFFFFC) begin bad++; $display("FAIL wrap_req0 got %h want fffffc", req_log[base % 64]); end
    total++; if (req_log[(base + 1) % 64] !== 24'h000000) begin bad++; $display("FAIL wrap_req1 got %h want 000000", req_log[(base + 1) % 64]); end
  endtask

  task automatic test_underrun();
    mem_lat = 40;
    xfer_head(8'h03, 24'h000004);
    xfer_data(2);
    xfer_end();
    total++; if (rx_buf[0] !== 8'h00) begin bad++; $display("FAIL underrun_byte got %h want 00", rx_buf[0]); end
    repeat (120) @(negedge clock);
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_sticky got %b want 1", underrun); end
    mem_lat = 2;
    xfer_head(8'h03, 24'h000004);
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_clear got %b want 0", underrun); end
    xfer_data(1);
    xfer_end();
    total++; if (rx_buf[0] !== 8'h11) begin bad++; $display("FAIL underrun_next got %h want 11", rx_buf[0]); end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    logic [7:0] exp [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    int base = req_total;
    spi_ss = 1'b0;
    repeat (HALF) @(negedge clock);
    spi_byte(8'h03, d);
    spi_byte(8'h00, d);
    for (int i = 0; i < 4; i++) begin
      spi_mosi = 1'b0;
      repeat (HALF) @(negedge clock);
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clock);
      spi_sck = 1'b0;
    end
    xfer_end();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got %b want 0", busy); end
    total++; if (req_total != base) begin bad++; $display("FAIL abort_noreq got %0d want %0d", req_total, base); end
    xfer_head(8'h03, 24'h000010);
    xfer_data(4);
    xfer_end();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx_buf[i] !== exp[i]) begin bad++; $display("FAIL abort_byte%0d got %h want %h", i, rx_buf[i], exp[i]); end
    end
    total++; if (req_log[base % 64] !== 24'h000010) begin bad++; $display("FAIL abort_req got %h want 000010", req_log[base % 64]); end
  endtask

  task automatic test_ignore();
    int base = req_total;
    xfer_head(8'hAB, 24'h000004);
    xfer_data(4);
    xfer_end();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx_buf[i] !== 8'h00) begin bad++; $display("FAIL ignore_byte%0d got %h want 00", i, rx_buf[i]); end
    end
    total++; if (req_total != base) begin bad++; $display("FAIL ignore_noreq got %0d want %0d", req_total, base); end
  endtask

  task automatic test_fast_read();
    logic [7:0] exp [4];
    int base = req_total;
`ifdef SPI_FLASH_FAST_READ_EN
    exp = '{8'h00, 8'h01, 8'h02, 8'h03};
`else
    exp = '{8'h00, 8'h00, 8'h00, 8'h00};
`endif
    xfer_head(8'h0B, 24'h000000);
    xfer_data(1);
    xfer_data(4);
    xfer_end();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx_buf[i] !== exp[i]) begin bad++; $display("FAIL fast_byte%0d got %h want %h", i, rx_buf[i], exp[i]); end
    end
`ifdef SPI_FLASH_FAST_READ_EN
    total++; if (req_log[base % 64] !== 24'h000000) begin bad++; $display("FAIL fast_req got %h want 000000", req_log[base % 64]); end
`else
    total++; if (req_total != base) begin bad++; $display("FAIL fast_noreq got %0d want %0d", req_total, base); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_cross_word();
    test_wrap();
    test_underrun();
    test_abort();
    test_ignore();
    test_fast_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI flash slave: the responder at the far end of the SPI master's flash XIP path. Supplies MISO data for the master's 0x03 read transfers.
- Oversamples SCK/SS/MOSI in the system clock domain, decodes command and 24-bit address, fetches 32-bit words from a backing memory port, and shifts bytes out MSB-first.
- Used as the on-board flash model in SoC simulation and FPGA bring-up.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on spi_sck/spi_ss/spi_mosi (min 2)
- ADDR_W, 24, flash byte-address width; address wraps modulo 2^ADDR_W

Ports:
- clock  in  1  system clock; must be >= 8x SCK frequency
- reset  in  1  synchronous, active-high
- spi_sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
- spi_ss  in  1  chip select, active-low
- spi_mosi  in  1  master-out data
- spi_miso  out  1  slave-out data
- mem_req  out  1  word read request, held until mem_ready
- mem_addr  out  ADDR_W  word-aligned byte address, low 2 bits 0, stable while mem_req=1
- mem_ready  in  1  one-cycle pulse; mem_rdata valid in the same cycle
- mem_rdata  in  32  little-endian word: byte at mem_addr+0 in [7:0]
- busy  out  1  high while SS asserted and the FSM is not IDLE
- underrun  out  1  sticky; cleared by reset or by the next SS falling edge

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high.
- Reset values: spi_miso=0, mem_req=0, mem_addr=0, busy=0, underrun=0, FSM=IDLE, counters 0.
- Synchronize spi_sck/spi_ss/spi_mosi through SYNC_STAGES flops. Edges are detected against a delayed copy of the synchronized SCK. MOSI is sampled on SCK rise; MISO is updated on SCK fall.
- States: IDLE, CMD, ADDR, DATA, IGNORE (plus DUMMY under the option).
- IDLE -> CMD when synchronized SS goes low; clear bit_cnt and underrun.
- CMD: shift 8 bits MSB-first on rises. On the 8th bit: 0x03 -> ADDR; any other value -> IGNORE.
- ADDR: shift 24 bits. On the 24th rise, latch byte_addr; set mem_req=1 with mem_addr={byte_addr[23:2],2'b00}; go to DATA.
- DATA:
  - When mem_ready arrives, load the word into the holding buffer, then issue a prefetch for mem_addr+4 (wraps).
  - The first output byte is byte byte_addr[1:0] of the word. Subsequent bytes increment the byte lane; after lane 3, continue from the prefetched word.
  - Each byte goes out MSB-first. The first MISO bit is driven on the first SCK fall after the 24th address bit.
  - If no valid byte is available at a fall where a new byte must start: drive 0 for that byte and set underrun=1.
- IGNORE: spi_miso=0 until SS deasserts.
- spi_miso=0 in every state other than DATA.
- SS deassert (synchronized high) in any state: FSM -> IDLE next cycle, buffer invalidated, spi_miso=0.
  - An outstanding mem_req stays high until mem_ready; that data is discarded.
  - A new transaction may start meanwhile. Its first request waits until the old one completes.
- At most one request is outstanding. The holding buffer and shifter give two-word buffering.
- Reset mid-transfer returns everything to reset values. Remaining SCK activity is ignored until SS deasserts and reasserts.
- The master's RX register receives the first transferred byte in its top byte. The SPI master bridge byte-swaps it, which yields the little-endian word.

Optional Feature:
- Macro: SPI_FLASH_FAST_READ_EN.
- Defined: command 0x0B (fast read) is accepted. ADDR -> DUMMY, which counts 8 SCK rises while issuing the memory request; then DATA as for 0x03. The first MISO bit comes on the fall after the 8th dummy rise.
- Undefined: 0x0B -> IGNORE like any unknown command.

Decomposition:
- Package spi_flash_pkg:
  - state enum
  - CMD_READ=8'h03, CMD_FAST_READ=8'h0B
  - DUMMY_CYCLES=8, ADDR_BITS=24
- One sub-module: spi_edge_sync. It holds the SYNC_STAGES synchronizers and produces sck_rise/sck_fall/ss_active/mosi_s. Reused by other SPI peripheral models.

Test Plan:
- 0x03, addr 0x000004, mem[0x4]=0x44332211, 32 SCKs -> MISO bytes 11,22,33,44; exactly one mem_req, mem_addr=0x000004.
- 0x03, addr 0x000006, 6 data bytes; mem[0x4]=0x44332211, mem[0x8]=0x88776655 -> 33,44,55,66,77,88; requests at 0x4 then 0x8.
- 0x03, addr 0xFFFFFC, 8 bytes -> requests 0xFFFFFC then 0x000000 (wrap); bytes from both words in order.
- mem_ready delayed past the first data fall -> first byte 0x00, underrun=1; the next SS fall clears underrun.
- SS raised after 12 address bits, then a fresh 0x03 to addr 0x10 -> busy=0 between transfers; the second read returns mem[0x10] correctly; no spurious request from the aborted transfer.
- Command 0xAB -> IGNORE, MISO stays 0, no mem_req. With SPI_FLASH_FAST_READ_EN: 0x0B, addr 0x0, 8 dummy clocks -> mem[0x0] bytes; without it, MISO stays 0.
